// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: instruction class codes, field
// positions and the opcode-to-class decoder.
package id_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_J = 3'd2,
    TYPE_S = 3'd3,
    TYPE_A = 3'd4
  } id_type_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int F_RS_LSB = 21;
  localparam int F_RD_LSB = 16;
  localparam int F_RT_LSB = 11;
  localparam int F_SH_LSB = 6;
  localparam int F_SI_LSB = 20;
  localparam int F_SX_LSB = 10;

  // opcode[5:4] selects the class; within class 11, opcode[3] splits S from A
  localparam logic [5:0] OP_CLASS_MASK = 6'b110000;
  localparam logic [5:0] OP_CLASS_R    = 6'b000000;
  localparam logic [5:0] OP_CLASS_I    = 6'b010000;
  localparam logic [5:0] OP_CLASS_J    = 6'b100000;
  localparam logic [5:0] OP_SA_MASK    = 6'b001000;

  function automatic id_type_e decode_type(input logic [5:0] op);
    if ((op & OP_CLASS_MASK) == OP_CLASS_R) return TYPE_R;
    if ((op & OP_CLASS_MASK) == OP_CLASS_I) return TYPE_I;
    if ((op & OP_CLASS_MASK) == OP_CLASS_J) return TYPE_J;
    return ((op & OP_SA_MASK) != 6'b0) ? TYPE_A : TYPE_S;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the ID stage.
// slave = the stage itself, master = the surrounding fetch/execute logic.
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic            ex_ready;
  logic            id_valid;
  logic [2:0]      id_type;
  logic [5:0]      id_opcode;
  logic [RA_W-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]      id_shamt;
  logic [5:0]      id_funct, id_s_index;
  logic [9:0]      id_s_x, id_s_y;
  logic [XLEN-1:0] id_pc;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  id_ready, id_valid, id_type, id_opcode,
           id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_funct, id_s_index, id_s_x, id_s_y, id_pc
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output id_ready, id_valid, id_type, id_opcode,
           id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_funct, id_s_index, id_s_x, id_s_y, id_pc
  );
endinterface

// File: rtl/id_regfile.sv
// 2-read/1-write GPR file. r0 reads zero; a write in flight is forwarded to
// readers in the same cycle so decode never sees a stale operand.
module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [XLEN-1:0]          ra_data,
  output logic [XLEN-1:0]          rb_data,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = (wb_en && wb_addr == ra_addr) ? wb_data : regs_q[ra_addr];
    if (rb_addr != '0) rb_data = (wb_en && wb_addr == rb_addr) ? wb_data : regs_q[rb_addr];
  end
endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: IF/ID holding register with valid/ready on both
// sides, register read with write-back bypass, load-use interlock and flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int IMM_SEXT_I = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  id_stage_pipe_if.slave           bus,
  input  logic                     flush,
  input  logic                     ex_ld_valid,
  input  logic [$clog2(NREGS)-1:0] ex_ld_rd,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data
);
  localparam int RA_W = $clog2(NREGS);

  logic            held_valid_q, held_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  id_type_e        typ;
  logic [RA_W-1:0] rs_a, rt_a, rd_a;
  logic [XLEN-1:0] rs_data, rt_data, imm;
  logic [4:0]      shamt;
  logic [5:0]      funct, s_index;
  logic [9:0]      s_x, s_y;
  logic            hazard, advance, capture;

  // Field extraction; addresses of registers a class does not use stay 0,
  // which also keeps them out of the hazard compare.
  always_comb begin
    typ     = decode_type(instr_q[OP_MSB:OP_LSB]);
    rs_a    = '0;
    rt_a    = '0;
    rd_a    = '0;
    imm     = '0;
    shamt   = '0;
    funct   = '0;
    s_index = '0;
    s_x     = '0;
    s_y     = '0;
    case (typ)
      TYPE_R: begin
        rs_a  = RA_W'(instr_q[F_RS_LSB +: 5]);
        rd_a  = RA_W'(instr_q[F_RD_LSB +: 5]);
        rt_a  = RA_W'(instr_q[F_RT_LSB +: 5]);
        shamt = instr_q[F_SH_LSB +: 5];
        funct = instr_q[5:0];
      end
      TYPE_I: begin
        rs_a = RA_W'(instr_q[F_RS_LSB +: 5]);
        rd_a = RA_W'(instr_q[F_RD_LSB +: 5]);
        imm  = (IMM_SEXT_I != 0) ? {{(XLEN-16){instr_q[15]}}, instr_q[15:0]}
                                 : {{(XLEN-16){1'b0}}, instr_q[15:0]};
      end
      TYPE_J: imm = {pc_q[XLEN-1:28], instr_q[25:0], 2'b00};
      TYPE_S: begin
        s_index = instr_q[F_SI_LSB +: 6];
        s_x     = instr_q[F_SX_LSB +: 10];
        s_y     = instr_q[9:0];
        funct   = instr_q[5:0];
        imm     = XLEN'(instr_q[7:0]);
      end
      TYPE_A: begin
        rs_a = RA_W'(instr_q[F_RS_LSB +: 5]);
        imm  = XLEN'(instr_q[20:0]);
      end
      default: ;
    endcase
  end

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs_a),
    .rb_addr (rt_a),
    .ra_data (rs_data),
    .rb_data (rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign hazard  = held_valid_q && ex_ld_valid && (ex_ld_rd != '0) &&
                   ((ex_ld_rd == rs_a) || (ex_ld_rd == rt_a));
  assign advance = bus.id_valid && bus.ex_ready;
  assign capture = bus.if_valid && bus.id_ready && !flush;

  assign bus.id_valid = held_valid_q && !hazard;
  assign bus.id_ready = !held_valid_q || advance;

  // Flush wins over both capture and hold; instr/pc only move on capture so
  // every output is frozen during a stall.
  always_comb begin
    held_valid_d = held_valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    if (flush)        held_valid_d = 1'b0;
    else if (capture) held_valid_d = 1'b1;
    else if (advance) held_valid_d = 1'b0;
    if (capture) begin
      instr_d = bus.if_instr;
      pc_d    = bus.if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_valid_q <= 1'b0;
      instr_q      <= '0;
      pc_q         <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
    end
  end

  assign bus.id_type    = typ;
  assign bus.id_opcode  = instr_q[OP_MSB:OP_LSB];
  assign bus.id_rs_addr = rs_a;
  assign bus.id_rt_addr = rt_a;
  assign bus.id_rd_addr = rd_a;
  assign bus.id_rs_data = rs_data;
  assign bus.id_rt_data = rt_data;
  assign bus.id_imm     = imm;
  assign bus.id_shamt   = shamt;
  assign bus.id_funct   = funct;
  assign bus.id_s_index = s_index;
  assign bus.id_s_x     = s_x;
  assign bus.id_s_y     = s_y;
  assign bus.id_pc      = pc_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected decodes are queued at issue and
// checked by a monitor on every EX-side transfer; control checks are inline.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ex_ld_valid, wb_en;
  logic [4:0]  ex_ld_rd, wb_addr;
  logic [31:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0]  typ;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  sh;
    logic [5:0]  fn, si;
    logic [9:0]  sx, sy;
    logic [31:0] pc;
  } dec_t;

  dec_t exp_q[$];
  dec_t act;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32), .RA_W(5)) bus ();

  id_stage_pipe #(.XLEN(32), .NREGS(32), .IMM_SEXT_I(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .ex_ld_valid (ex_ld_valid),
    .ex_ld_rd    (ex_ld_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  assign act = {bus.id_type, bus.id_opcode, bus.id_rs_addr, bus.id_rt_addr, bus.id_rd_addr,
                bus.id_rs_data, bus.id_rt_data, bus.id_imm, bus.id_shamt, bus.id_funct,
                bus.id_s_index, bus.id_s_x, bus.id_s_y, bus.id_pc};

  function automatic dec_t mk(input logic [2:0] t, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                              input logic [4:0] sh, input logic [5:0] fn, input logic [5:0] si,
                              input logic [9:0] sx, input logic [9:0] sy, input logic [31:0] pc);
    return {t, op, rs, rt, rd, rsd, rtd, imm, sh, fn, si, sx, sy, pc};
  endfunction

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  // Present one instruction and return just after the edge that captured it.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    n = 0;
    bus.if_valid = 1'b1; bus.if_instr = ins; bus.if_pc = pc;
    @(negedge clk);
    while (!bus.id_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 192'(bus.id_ready), 192'(1));
    tick();
    bus.if_valid = 1'b0;
  endtask

  // Scoreboard monitor: every EX-side transfer must match the oldest expectation.
  initial begin
    dec_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.id_valid && bus.ex_ready) begin
        if (exp_q.size() == 0) chk("unexpected_xfer", 192'(act), 192'(0));
        else begin
          e = exp_q.pop_front();
          chk("xfer_decode", 192'(act), 192'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; ex_ld_valid = 1'b0; ex_ld_rd = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
    #2;
    chk("rst_valid", 192'(bus.id_valid), 192'(0));
    chk("rst_ready", 192'(bus.id_ready), 192'(1));
    chk("rst_outputs", 192'(act), 192'(0));
    @(posedge clk); tick();
    rst = 1'b1;

    wr(5'd2, 32'd5); wr(5'd3, 32'd7); wr(5'd5, 32'd9);

    // R-type rs=2 rt=3 rd=4 shamt=3 funct=0x20, then I and J
    bus.ex_ready = 1'b1;
    exp_q.push_back(mk(3'd0, 6'h00, 5'd2, 5'd3, 5'd4, 32'd5, 32'd7, 32'd0, 5'd3, 6'h20, 6'd0, 10'd0, 10'd0, 32'h100));
    send(32'h004418E0, 32'h100);
    @(negedge clk); chk("r_latency_valid", 192'(bus.id_valid), 192'(1));
    tick();
    exp_q.push_back(mk(3'd1, 6'h10, 5'd2, 5'd0, 5'd6, 32'd5, 32'd0, 32'hFFFFFFFE, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h104));
    send(32'h4046FFFE, 32'h104);
    exp_q.push_back(mk(3'd2, 6'h20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h30000040, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h30000000));
    send(32'h80000010, 32'h30000000);
    tick();

    // Load-use on R5 for two cycles
    ex_ld_valid = 1'b1; ex_ld_rd = 5'd5;
    exp_q.push_back(mk(3'd0, 6'h00, 5'd5, 5'd0, 5'd7, 32'd9, 32'd0, 32'd0, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h110));
    send(32'h00A70000, 32'h110);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("hz_valid", 192'(bus.id_valid), 192'(0));
      chk("hz_ready", 192'(bus.id_ready), 192'(0));
      chk("hz_stable", 192'(act), 192'(mk(3'd0, 6'h00, 5'd5, 5'd0, 5'd7, 32'd9, 32'd0, 32'd0, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h110)));
      tick();
    end
    ex_ld_valid = 1'b0;
    @(negedge clk); chk("hz_release", 192'(bus.id_valid), 192'(1));
    tick();

    // ex_ld_rd=0 and a match on a non-source field must not stall
    ex_ld_valid = 1'b1; ex_ld_rd = 5'd0;
    exp_q.push_back(mk(3'd0, 6'h00, 5'd0, 5'd3, 5'd1, 32'd0, 32'd7, 32'd0, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h114));
    send(32'h00011800, 32'h114);
    @(negedge clk); chk("nohz_rd0", 192'(bus.id_valid), 192'(1));
    tick();
    ex_ld_rd = 5'd5;
    exp_q.push_back(mk(3'd1, 6'h10, 5'd2, 5'd0, 5'd5, 32'd5, 32'd0, 32'd1, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h118));
    send(32'h40450001, 32'h118);
    @(negedge clk); chk("nohz_unused", 192'(bus.id_valid), 192'(1));
    tick();
    ex_ld_valid = 1'b0;

    // Write-back bypass to a held instruction, and R0 stays zero
    bus.ex_ready = 1'b0;
    exp_q.push_back(mk(3'd0, 6'h00, 5'd2, 5'd0, 5'd8, 32'hDEAD, 32'd0, 32'd0, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h120));
    send(32'h00480000, 32'h120);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD;
    @(negedge clk); chk("bypass_rs", 192'(bus.id_rs_data), 192'(32'hDEAD));
    tick();
    wb_addr = 5'd0; wb_data = 32'h1234;
    @(negedge clk);
    chk("bypass_r0", 192'(bus.id_rt_data), 192'(0));
    chk("committed_rs", 192'(bus.id_rs_data), 192'(32'hDEAD));
    tick();
    wb_en = 1'b0;
    @(negedge clk); chk("r0_not_written", 192'(bus.id_rt_data), 192'(0));
    tick();
    bus.ex_ready = 1'b1;
    tick();

    // Flush with a held instruction, then flush beating capture on an empty stage
    bus.ex_ready = 1'b0;
    send(32'h004418E0, 32'h130);
    flush = 1'b1; bus.if_valid = 1'b1; bus.if_instr = 32'h00A70000; bus.if_pc = 32'h134;
    tick();
    flush = 1'b0; bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 192'(bus.id_valid), 192'(0));
    chk("flush_ready", 192'(bus.id_ready), 192'(1));
    tick();
    flush = 1'b1; bus.if_valid = 1'b1;
    @(negedge clk); chk("flush_prio_ready", 192'(bus.id_ready), 192'(1));
    tick();
    flush = 1'b0; bus.if_valid = 1'b0;
    @(negedge clk); chk("flush_prio_valid", 192'(bus.id_valid), 192'(0));
    tick();

    // Back-to-back stream: one per cycle, no bubbles
    bus.ex_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.if_valid = 1'b1;
      bus.if_instr = 32'h40600000 | (32'(i) << 16) | 32'(i);
      bus.if_pc    = 32'h200 + 32'(4 * i);
      exp_q.push_back(mk(3'd1, 6'h10, 5'd3, 5'd0, 5'(i), 32'd7, 32'd0, 32'(i), 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h200 + 32'(4 * i)));
      @(negedge clk);
      chk("b2b_ready", 192'(bus.id_ready), 192'(1));
      if (i > 1) chk("b2b_valid", 192'(bus.id_valid), 192'(1));
      tick();
    end
    bus.if_valid = 1'b0;
    @(negedge clk); chk("b2b_last_valid", 192'(bus.id_valid), 192'(1));
    tick();
    @(negedge clk);
    chk("b2b_idle", 192'(bus.id_valid), 192'(0));
    chk("b2b_drained", 192'(exp_q.size()), 192'(0));
    tick();

    // S-type and A-type field extraction
    exp_q.push_back(mk(3'd3, 6'h30, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hAA, 5'd0, 6'h2A, 6'h2A, 10'h155, 10'h0AA, 32'h300));
    send(32'hC2A554AA, 32'h300);
    exp_q.push_back(mk(3'd4, 6'h38, 5'd2, 5'd0, 5'd0, 32'hDEAD, 32'd0, 32'h001FFFFF, 5'd0, 6'd0, 6'd0, 10'd0, 10'd0, 32'h304));
    send(32'hE05FFFFF, 32'h304);
    tick(); tick();

    // Asynchronous reset in the middle of a stall
    bus.ex_ready = 1'b0; ex_ld_valid = 1'b1; ex_ld_rd = 5'd2;
    send(32'h004418E0, 32'h400);
    @(negedge clk); chk("stall_before_rst", 192'(bus.id_valid), 192'(0));
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 192'(bus.id_valid), 192'(0));
    chk("async_rst_ready", 192'(bus.id_ready), 192'(1));
    chk("async_rst_outputs", 192'(act), 192'(0));
    ex_ld_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk); chk("held_discarded", 192'(bus.id_valid), 192'(0));
    chk("queue_empty", 192'(exp_q.size()), 192'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
